uart_echo: RTL and testbench
============================

# uart_echo

Byte-echo responder between the receiver's parallel output (`rx_done_tick`/`dout`) and the transmitter's parallel input (`tx_start`/`din`/`tx_done_tick`). Every received byte is queued in a small FIFO and retransmitted in order, one frame at a time, paced by the transmitter's done tick. It is the far end of the UART loopback bench: board-level echo and host-driven link tests both use it.

## Interface
- `FIFO_AW`, 3: FIFO address width; depth = 2**FIFO_AW (8).
- `clk` in 1: system clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `rx_done_tick` in 1: one-cycle pulse; `rx_dout` is valid in that cycle.
- `rx_dout` in 8: received byte.
- `tx_done_tick` in 1: one-cycle pulse from the transmitter when the stop bit completes.
- `tx_start` out 1: one-cycle pulse that starts a transmitter frame.
- `tx_din` out 8: byte to transmit; held stable from `tx_start` until `tx_done_tick`.
- `ovr_clr` in 1: synchronous clear of `overrun` and `ovr_count`.
- `fifo_empty` out 1: FIFO holds 0 entries.
- `fifo_full` out 1: FIFO holds 2**FIFO_AW entries.
- `overrun` out 1: sticky; set when a received byte was dropped.
- `ovr_count` out 8: number of dropped bytes, saturating at 255.

## Operation
- FIFO:
  - Registered circular buffer; read and write pointers are FIFO_AW+1 bits, so wrap-around is handled by pointer arithmetic.
  - `fifo_full`/`fifo_empty` come from pointer compare.
  - Push occurs on `rx_done_tick`.
- FSM states: IDLE, START, BUSY.
  - IDLE: if `!fifo_empty`, pop the head into the `tx_din` register and go to START. Otherwise stay.
  - START: `tx_start`=1 for exactly this cycle, then go to BUSY.
  - BUSY: wait for `tx_done_tick`, then go to IDLE. Pops and `tx_start` are blocked while in BUSY.
- Overrun:
  - `rx_done_tick` while `fifo_full` and no pop in the same cycle: the byte is discarded.
  - In that case `overrun`←1 and `ovr_count`←min(`ovr_count`+1, 255).
- Simultaneous push and pop:
  - Both take effect; the count is unchanged.
  - When full, a same-cycle pop frees the slot, so the push is accepted and no overrun is raised.
- Simultaneous `ovr_clr` and a drop: the clear wins, giving `overrun`=0 and `ovr_count`=0.
- `tx_done_tick` outside BUSY is ignored.

## Timing
- Reset values:
  - `tx_start`=0, `tx_din`=8'h00.
  - `fifo_empty`=1, `fifo_full`=0.
  - `overrun`=0, `ovr_count`=0.
  - State IDLE, pointers 0.
- Reset mid-frame: the FSM returns to IDLE and queued bytes are lost. A `tx_done_tick` arriving after reset release is ignored.
- Latency, with `rx_done_tick` high in cycle N and the FIFO empty and idle:
  - Write at the edge ending cycle N; `fifo_empty`=0 in cycle N+1.
  - Pop at the edge ending N+1; state START in cycle N+2.
  - `tx_start`=1 in cycle N+2; `tx_din` is valid from cycle N+2.
- Back-to-back:
  - `tx_done_tick` in cycle M gives IDLE in M+1, START in M+2 if data is queued.
  - Inter-frame gap is therefore 2 cycles after done.
- The status outputs are registered or decoded directly from registered pointers; there are no combinational paths from inputs to outputs.

## Configuration
- `UART_ECHO_UPPER_EN`:
  - Defined: a popped byte in 8'h61–8'h7A (ASCII a–z) is loaded into `tx_din` with bit 5 cleared (converted to A–Z). All other bytes pass unchanged.
  - Undefined: bytes are echoed verbatim. The FIFO stores raw bytes in both builds.

## Test plan
- Single byte: `rx_done_tick` with 8'hA5 in cycle N, then `tx_start` pulse in N+2 with `tx_din`=8'hA5. After `tx_done_tick`, `fifo_empty`=1.
- Burst: push 8'h00, 8'h55, 8'hAA, 8'hFF on consecutive cycles. Exactly four `tx_start` pulses, in that order, each only after the prior `tx_done_tick`.
- Overrun: hold off `tx_done_tick`, push 10 bytes.
  - 1 byte is in the transmitter and 8 are queued, so `fifo_full`=1.
  - 1 byte is dropped: `overrun`=1, `ovr_count`=1.
  - Pulse `ovr_clr`: both return to 0.
- Wrap and full pop/push: cycle 20 bytes through the FIFO and confirm order is preserved. With `fifo_full`=1, pulse `tx_done_tick` so that the pop lands in the same cycle as a push: no overrun.
- Reset mid-operation: assert `reset` while in BUSY with 3 bytes queued. All outputs return to reset values immediately, and no `tx_start` occurs after release.
- With `UART_ECHO_UPPER_EN`: push 8'h61, 8'h7A, 8'h7B, which echo as 8'h41, 8'h5A, 8'h7B. Without the macro, all three echo verbatim.

Source files
------------

// File: rtl/uart_echo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_echo
//  Purpose  : Byte-echo responder. Every byte delivered by the UART receiver
//             is queued in a small circular FIFO and handed back to the UART
//             transmitter in order, one frame at a time, paced by the
//             transmitter's done tick. Dropped bytes (FIFO full, no pop in the
//             same cycle) are flagged with a sticky overrun bit and counted.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    FIFO_AW       FIFO address width; depth = 2**FIFO_AW
//  Ports
//    clk           in   system clock, rising edge
//    reset         in   asynchronous active-high reset
//    rx_done_tick  in   one-cycle pulse, rx_dout valid in that cycle
//    rx_dout       in   [7:0] received byte
//    tx_done_tick  in   one-cycle pulse when the transmitter's stop bit ends
//    ovr_clr       in   synchronous clear of overrun / ovr_count
//    tx_start      out  one-cycle pulse starting a transmitter frame
//    tx_din        out  [7:0] byte to transmit, held until tx_done_tick
//    fifo_empty    out  FIFO holds no entries
//    fifo_full     out  FIFO holds 2**FIFO_AW entries
//    overrun       out  sticky, set when a received byte was dropped
//    ovr_count     out  [7:0] dropped-byte count, saturates at 255
//  Build option
//    UART_ECHO_UPPER_EN  when defined, lowercase ASCII (a-z) is echoed as
//                        uppercase; the FIFO always stores raw bytes
// ============================================================================
module uart_echo #(
    parameter int FIFO_AW = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_dout,
    input  logic       tx_done_tick,
    input  logic       ovr_clr,
    output logic       tx_start,
    output logic [7:0] tx_din,
    output logic       fifo_empty,
    output logic       fifo_full,
    output logic       overrun,
    output logic [7:0] ovr_count
);

    localparam int c_depth = 1 << FIFO_AW;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [7:0]         r_mem [c_depth];
    logic [FIFO_AW:0]   r_wr_ptr;
    logic [FIFO_AW:0]   r_rd_ptr;
    logic [7:0]         r_tx_din;
    logic               r_overrun;
    logic [7:0]         r_ovr_count;

    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic [7:0]         w_head;
    logic [7:0]         w_load_byte;

    // The extra pointer MSB distinguishes full from empty when the address
    // bits coincide.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]) &&
                     (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]);

    // Pop only from IDLE; a pop never bypasses an empty FIFO, so a byte always
    // spends at least one cycle in storage.
    assign w_pop  = (r_state == ST_IDLE) && !w_empty;
    // A same-cycle pop frees the slot, so a push into a full FIFO is accepted.
    assign w_push = rx_done_tick && (!w_full || w_pop);
    assign w_drop = rx_done_tick && w_full && !w_pop;

    assign w_head = r_mem[r_rd_ptr[FIFO_AW-1:0]];

`ifdef UART_ECHO_UPPER_EN
    always_comb begin
        w_load_byte = w_head;
        if ((w_head >= 8'h61) && (w_head <= 8'h7A)) begin
            w_load_byte = w_head & 8'hDF;
        end
    end
`else
    assign w_load_byte = w_head;
`endif

    // Storage array carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[FIFO_AW-1:0]] <= rx_dout;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_tx_din <= 8'h00;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_tx_din <= w_load_byte;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (!w_empty) w_state_nxt = ST_START;
            ST_START: w_state_nxt = ST_BUSY;
            ST_BUSY:  if (tx_done_tick) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Clear takes priority over a coincident drop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overrun   <= 1'b0;
            r_ovr_count <= 8'h00;
        end else if (ovr_clr) begin
            r_overrun   <= 1'b0;
            r_ovr_count <= 8'h00;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
            if (r_ovr_count != 8'hFF) begin
                r_ovr_count <= r_ovr_count + 8'h01;
            end
        end
    end

    assign tx_start   = (r_state == ST_START);
    assign tx_din     = r_tx_din;
    assign fifo_empty = w_empty;
    assign fifo_full  = w_full;
    assign overrun    = r_overrun;
    assign ovr_count  = r_ovr_count;

endmodule
`default_nettype wire

// File: tb/tb_uart_echo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_echo
//  Purpose  : Directed self-checking bench for uart_echo.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_echo;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_done_tick = 1'b0;
    logic [7:0] rx_dout = 8'h00;
    logic       tx_done_tick = 1'b0;
    logic       ovr_clr = 1'b0;
    logic       tx_start;
    logic [7:0] tx_din;
    logic       fifo_empty;
    logic       fifo_full;
    logic       overrun;
    logic [7:0] ovr_count;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         start_cnt = 0;
    logic [7:0] log_q[$];
    logic [7:0] exp_q[$];

    uart_echo #(.FIFO_AW(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_done_tick (rx_done_tick),
        .rx_dout      (rx_dout),
        .tx_done_tick (tx_done_tick),
        .ovr_clr      (ovr_clr),
        .tx_start     (tx_start),
        .tx_din       (tx_din),
        .fifo_empty   (fifo_empty),
        .fifo_full    (fifo_full),
        .overrun      (overrun),
        .ovr_count    (ovr_count)
    );

    always #5 clk = ~clk;

    // Record every frame start with the byte presented to the transmitter.
    always @(negedge clk) begin
        if (tx_start === 1'b1) begin
            start_cnt++;
            log_q.push_back(tx_din);
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b, input bit keep);
        rx_dout      = b;
        rx_done_tick = 1'b1;
        tick();
        rx_done_tick = 1'b0;
        if (keep) exp_q.push_back(b);
    endtask

    task automatic send_done();
        tx_done_tick = 1'b1;
        tick();
        tx_done_tick = 1'b0;
    endtask

    task automatic wait_start(input string tag, input logic [7:0] exp);
        int n;
        n = 0;
        while (tx_start !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check_val({tag, "_start"}, {31'd0, tx_start}, 32'd1);
        check_val({tag, "_din"}, {24'd0, tx_din}, {24'd0, exp});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int saved;
        logic [7:0] up_exp [3];

        // ---------------- reset values
        repeat (2) tick();
        check_val("rst_tx_start", {31'd0, tx_start}, 32'd0);
        check_val("rst_tx_din", {24'd0, tx_din}, 32'h00);
        check_val("rst_empty", {31'd0, fifo_empty}, 32'd1);
        check_val("rst_full", {31'd0, fifo_full}, 32'd0);
        check_val("rst_overrun", {31'd0, overrun}, 32'd0);
        check_val("rst_ovr_count", {24'd0, ovr_count}, 32'd0);
        reset = 1'b0;
        tick();

        // ---------------- single byte, exact latency
        push(8'hA5, 1'b1);                       // now in cycle N+1
        check_val("single_empty_n1", {31'd0, fifo_empty}, 32'd0);
        check_val("single_start_n1", {31'd0, tx_start}, 32'd0);
        tick();                                  // cycle N+2
        check_val("single_start_n2", {31'd0, tx_start}, 32'd1);
        check_val("single_din_n2", {24'd0, tx_din}, 32'hA5);
        check_val("single_empty_n2", {31'd0, fifo_empty}, 32'd1);
        tick();
        check_val("single_start_n3", {31'd0, tx_start}, 32'd0);
        repeat (3) tick();
        send_done();
        tick();
        check_val("single_empty_end", {31'd0, fifo_empty}, 32'd1);
        check_val("single_din_hold", {24'd0, tx_din}, 32'hA5);
        // done tick while idle must not start anything
        saved = start_cnt;
        send_done();
        repeat (3) tick();
        check_val("idle_done_ignored", start_cnt, saved + 1 - 1);

        // ---------------- burst of four
        saved = start_cnt;
        push(8'h00, 1'b1);
        push(8'h55, 1'b1);
        push(8'hAA, 1'b1);
        push(8'hFF, 1'b1);
        for (int i = 0; i < 4; i++) begin
            repeat (4) tick();
            check_val($sformatf("burst_cnt%0d", i), start_cnt, saved + i + 1);
            send_done();
            repeat (3) tick();
        end
        check_val("burst_total", start_cnt, saved + 4);
        check_val("burst_b0", {24'd0, log_q[1]}, 32'h00);
        check_val("burst_b1", {24'd0, log_q[2]}, 32'h55);
        check_val("burst_b2", {24'd0, log_q[3]}, 32'hAA);
        check_val("burst_b3", {24'd0, log_q[4]}, 32'hFF);
        check_val("burst_empty", {31'd0, fifo_empty}, 32'd1);

        // ---------------- overrun: 1 in transmitter, 8 queued, 1 dropped
        for (int i = 0; i < 9; i++) push(8'h10 + 8'(i), 1'b1);
        check_val("ovr_pre_flag", {31'd0, overrun}, 32'd0);
        push(8'h19, 1'b0);
        check_val("ovr_full", {31'd0, fifo_full}, 32'd1);
        check_val("ovr_flag", {31'd0, overrun}, 32'd1);
        check_val("ovr_count1", {24'd0, ovr_count}, 32'd1);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        check_val("ovr_clr_flag", {31'd0, overrun}, 32'd0);
        check_val("ovr_clr_count", {24'd0, ovr_count}, 32'd0);
        check_val("ovr_clr_full", {31'd0, fifo_full}, 32'd1);
        // clear coincident with a drop: clear wins
        push(8'h1A, 1'b0);
        check_val("ovr_count_again", {24'd0, ovr_count}, 32'd1);
        ovr_clr = 1'b1;
        push(8'h1B, 1'b0);
        ovr_clr = 1'b0;
        check_val("clr_vs_drop_flag", {31'd0, overrun}, 32'd0);
        check_val("clr_vs_drop_count", {24'd0, ovr_count}, 32'd0);
        // saturation
        for (int i = 0; i < 256; i++) push(8'h1C, 1'b0);
        check_val("ovr_sat", {24'd0, ovr_count}, 32'd255);
        push(8'h1C, 1'b0);
        check_val("ovr_sat_hold", {24'd0, ovr_count}, 32'd255);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        check_val("ovr_sat_clr", {24'd0, ovr_count}, 32'd0);

        // ---------------- full FIFO: pop and push in the same cycle, 20 times
        for (int k = 0; k < 20; k++) begin
            send_done();                         // IDLE next cycle -> pop
            push(8'h80 + 8'(k), 1'b1);           // lands on the pop cycle
            tick();
            check_val($sformatf("wrap_ovr%0d", k), {31'd0, overrun}, 32'd0);
            check_val($sformatf("wrap_full%0d", k), {31'd0, fifo_full}, 32'd1);
        end
        for (int k = 0; k < 9; k++) begin
            send_done();
            repeat (4) tick();
        end
        check_val("wrap_empty", {31'd0, fifo_empty}, 32'd1);
        check_val("log_len", log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            check_val($sformatf("log%0d", i), {24'd0, log_q[i]}, {24'd0, exp_q[i]});
        end

        // ---------------- reset mid-frame with 3 queued
        push(8'hC0, 1'b0);
        push(8'hC1, 1'b0);
        push(8'hC2, 1'b0);
        push(8'hC3, 1'b0);
        repeat (4) tick();
        check_val("midrst_pre_empty", {31'd0, fifo_empty}, 32'd0);
        check_val("midrst_pre_din", {24'd0, tx_din}, 32'hC0);
        #2;
        reset = 1'b1;
        #1;
        check_val("midrst_tx_start", {31'd0, tx_start}, 32'd0);
        check_val("midrst_tx_din", {24'd0, tx_din}, 32'h00);
        check_val("midrst_empty", {31'd0, fifo_empty}, 32'd1);
        check_val("midrst_full", {31'd0, fifo_full}, 32'd0);
        check_val("midrst_overrun", {31'd0, overrun}, 32'd0);
        check_val("midrst_count", {24'd0, ovr_count}, 32'd0);
        tick();
        reset = 1'b0;
        saved = start_cnt;
        send_done();
        repeat (10) tick();
        check_val("midrst_no_start", start_cnt, saved);
        check_val("midrst_post_empty", {31'd0, fifo_empty}, 32'd1);

        // ---------------- lowercase conversion option
`ifdef UART_ECHO_UPPER_EN
        up_exp[0] = 8'h41;
        up_exp[1] = 8'h5A;
        up_exp[2] = 8'h7B;
`else
        up_exp[0] = 8'h61;
        up_exp[1] = 8'h7A;
        up_exp[2] = 8'h7B;
`endif
        push(8'h61, 1'b0);
        wait_start("case_61", up_exp[0]);
        tick();
        send_done();
        push(8'h7A, 1'b0);
        wait_start("case_7a", up_exp[1]);
        tick();
        send_done();
        push(8'h7B, 1'b0);
        wait_start("case_7b", up_exp[2]);
        tick();
        send_done();
        repeat (3) tick();
        check_val("final_empty", {31'd0, fifo_empty}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
